stamp_sequencer: RTL and testbench



---
 rtl/stamp_sequencer_pkg.sv | 39 +++
 rtl/stamp_sequencer_if.sv | 27 ++
 rtl/stamp_sequencer_leap_tracker.sv | 28 ++
 rtl/stamp_sequencer.sv | 144 ++++++++++++++
 tb/tb_stamp_sequencer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/stamp_sequencer_pkg.sv
// Shared types, constants and BCD/calendar helpers for the epoch-timestamp sequencer.
package stamp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        YEARS,
        MONTHS,
        TOD,
        DONE
    } state_e;

    localparam int unsigned EPOCH_YEAR        = 1970;
    localparam int unsigned SEC_PER_DAY       = 86400;
    localparam int unsigned SEC_PER_YEAR      = 31536000;
    localparam int unsigned SEC_PER_LEAP_YEAR = 31622400;

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                      return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
            default:                   return 5'd31;
        endcase
    endfunction

    function automatic logic [13:0] bcd2bin16(input logic [15:0] b);
        return 14'(b[15:12]) * 14'd1000 + 14'(b[11:8]) * 14'd100
             + 14'(b[7:4]) * 14'd10 + 14'(b[3:0]);
    endfunction

    function automatic logic [6:0] bcd2bin8(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic bcd_digits_ok(input logic [15:0] b);
        return (b[15:12] <= 4'd9) && (b[11:8] <= 4'd9) && (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/stamp_sequencer_if.sv
// Request/response bundle between the calendar source, the sequencer and the epoch consumer.
interface stamp_sequencer_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] year_bcd;
    logic [7:0]  month_bcd;
    logic [7:0]  day_bcd;
    logic [7:0]  hour_bcd;
    logic [7:0]  minute_bcd;
    logic [7:0]  second_bcd;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] time_stamp;
    logic        err;

    modport master (
        output in_valid, year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd, out_ready,
        input  in_ready, out_valid, time_stamp, err
    );

    modport slave (
        input  in_valid, year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd, out_ready,
        output in_ready, out_valid, time_stamp, err
    );

endinterface

// File: rtl/stamp_sequencer_leap_tracker.sv
// Divider-free leap-year detector: year mod 4/100/400 counters stepped alongside the year walk.
module leap_tracker (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic step_i,
    output logic leap_o
);

    logic [1:0] mod4_q;
    logic [6:0] mod100_q;
    logic [8:0] mod400_q;

    always_ff @(posedge clk) begin
        if (!rst_n || load_i) begin
            mod4_q   <= 2'd2;
            mod100_q <= 7'd70;
            mod400_q <= 9'd370;
        end else if (step_i) begin
            mod4_q   <= mod4_q + 2'd1;
            mod100_q <= (mod100_q == 7'd99)  ? '0 : mod100_q + 7'd1;
            mod400_q <= (mod400_q == 9'd399) ? '0 : mod400_q + 9'd1;
        end
    end

    always_comb leap_o = ((mod4_q == 2'd0) && (mod100_q != 7'd0)) || (mod400_q == 9'd0);

endmodule

// File: rtl/stamp_sequencer.sv
// BCD calendar time to Unix epoch seconds, walking years then months then time of day.
// Optional range checking is enabled by defining STAMP_RANGE_CHECK_EN.
module stamp_sequencer
    import stamp_pkg::*;
(
    input logic               clk,
    input logic               rst_n,
    stamp_sequencer_if.slave  bus
);

    state_e      state_q;
    logic        in_ready_q, out_valid_q, err_q;
    logic [63:0] stamp_q, acc_q;
    logic [15:0] ybcd_q;
    logic [7:0]  mbcd_q, dbcd_q, hbcd_q, nbcd_q, sbcd_q;
    logic [13:0] year_q, y_q;
    logic [3:0]  month_q, m_q;
    logic [4:0]  day_q, hour_q;
    logic [5:0]  min_q, sec_q;

    logic        leap, load_d, step_d, range_err;
    logic [63:0] tod_secs;

    always_comb begin
        load_d = (state_q == CONV);
        step_d = (state_q == YEARS) && !err_q && (y_q != year_q);
    end

    leap_tracker u_leap (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_d),
        .step_i (step_d),
        .leap_o (leap)
    );

`ifdef STAMP_RANGE_CHECK_EN
    always_comb begin
        range_err = !bcd_digits_ok(ybcd_q)
                 || !bcd_digits_ok({mbcd_q, dbcd_q}) || !bcd_digits_ok({hbcd_q, nbcd_q})
                 || !bcd_digits_ok({sbcd_q, 8'h00})
                 || (bcd2bin16(ybcd_q) < 14'(EPOCH_YEAR))
                 || (bcd2bin8(mbcd_q) == 7'd0) || (bcd2bin8(mbcd_q) > 7'd12)
                 || (bcd2bin8(dbcd_q) == 7'd0) || (bcd2bin8(dbcd_q) > 7'd31)
                 || (bcd2bin8(hbcd_q) > 7'd23) || (bcd2bin8(nbcd_q) > 7'd59)
                 || (bcd2bin8(sbcd_q) > 7'd59);
    end
`else
    always_comb range_err = 1'b0;
`endif

    always_comb begin
        tod_secs = (64'(day_q) - 64'd1) * 64'(SEC_PER_DAY) + 64'(hour_q) * 64'd3600
                 + 64'(min_q) * 64'd60 + 64'(sec_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            stamp_q     <= '0;
            acc_q       <= '0;
            ybcd_q      <= '0;
            {mbcd_q, dbcd_q, hbcd_q, nbcd_q, sbcd_q} <= '0;
            year_q      <= '0;
            y_q         <= '0;
            month_q     <= '0;
            m_q         <= '0;
            {day_q, hour_q, min_q, sec_q} <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        ybcd_q     <= bus.year_bcd;
                        mbcd_q     <= bus.month_bcd;
                        dbcd_q     <= bus.day_bcd;
                        hbcd_q     <= bus.hour_bcd;
                        nbcd_q     <= bus.minute_bcd;
                        sbcd_q     <= bus.second_bcd;
                        in_ready_q <= 1'b0;
                        state_q    <= CONV;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                CONV: begin
                    year_q  <= bcd2bin16(ybcd_q);
                    month_q <= 4'(bcd2bin8(mbcd_q));
                    day_q   <= 5'(bcd2bin8(dbcd_q));
                    hour_q  <= 5'(bcd2bin8(hbcd_q));
                    min_q   <= 6'(bcd2bin8(nbcd_q));
                    sec_q   <= 6'(bcd2bin8(sbcd_q));
                    err_q   <= range_err;
                    acc_q   <= '0;
                    y_q     <= 14'(EPOCH_YEAR);
                    m_q     <= 4'd1;
                    state_q <= YEARS;
                end
                YEARS: begin
                    // A range error latched in CONV exits here so the error reply lands two cycles after accept.
                    if (err_q) begin
                        stamp_q     <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else if (y_q == year_q) begin
                        state_q <= MONTHS;
                    end else begin
                        acc_q <= acc_q + (leap ? 64'(SEC_PER_LEAP_YEAR) : 64'(SEC_PER_YEAR));
                        y_q   <= y_q + 14'd1;
                    end
                end
                MONTHS: begin
                    if (m_q == month_q) begin
                        state_q <= TOD;
                    end else begin
                        acc_q <= acc_q + 64'(days_in_month(m_q, leap)) * 64'(SEC_PER_DAY);
                        m_q   <= m_q + 4'd1;
                    end
                end
                TOD: begin
                    stamp_q     <= acc_q + tod_secs;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.time_stamp = stamp_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_stamp_sequencer.sv
// Self-checking bench for stamp_sequencer: directed table, random dates vs calendar model, corner sequences.
module tb_stamp_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    stamp_sequencer_if bus();

    stamp_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          y, mo, d, h, mi, s;
        longint unsigned stamp;
        int          n;
    } vec_t;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic bit is_leap(input int y);
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
    endfunction

    function automatic int dim(input int y, input int mo);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        return (mo == 2 && is_leap(y)) ? 29 : t[mo-1];
    endfunction

    function automatic longint leaps_upto(input longint x);
        return x / 4 - x / 100 + x / 400;
    endfunction

    function automatic longint unsigned ref_stamp(input int y, mo, d, h, mi, s);
        int cum[12] = '{0, 31, 59, 90, 120, 151, 181, 212, 243, 273, 304, 334};
        longint days;
        days = 365 * longint'(y - 1970) + leaps_upto(y - 1) - leaps_upto(1969)
             + cum[mo-1] + ((mo > 2 && is_leap(y)) ? 1 : 0) + d - 1;
        return days * 86400 + h * 3600 + mi * 60 + s;
    endfunction

    function automatic logic [15:0] bcd16(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic issue(input int y, mo, d, h, mi, s);
        int unsigned w = 0;
        while (!bus.in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!bus.in_ready) check("in_ready_wait", 0, 1);
        bus.year_bcd   = bcd16(y);
        bus.month_bcd  = bcd8(mo);
        bus.day_bcd    = bcd8(d);
        bus.hour_bcd   = bcd8(h);
        bus.minute_bcd = bcd8(mi);
        bus.second_bcd = bcd8(s);
        bus.in_valid   = 1'b1;
        @(posedge clk); #1;
        bus.in_valid   = 1'b0;
        // fields must have been captured at accept
        bus.year_bcd   = 16'(  $urandom);
        bus.month_bcd  = 8'($urandom);
        bus.day_bcd    = 8'($urandom);
    endtask

    task automatic await_result(output longint unsigned st, output bit e, output int n, output bit to);
        n = 0;
        while (!bus.out_valid && n < 9000) begin
            @(posedge clk); #1; n++;
        end
        to = !bus.out_valid;
        st = bus.time_stamp;
        e  = bus.err;
    endtask

    task automatic take();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("take_out_valid", bus.out_valid, 0);
        check("take_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        vec_t vecs[6];
        longint unsigned st;
        bit e, to;
        int n, saw;

        vecs[0] = '{1970, 1, 1, 0, 0, 0, 64'd0, 4};
        vecs[1] = '{2024, 9, 2, 12, 34, 56, 64'd1725280496, 66};
        vecs[2] = '{2000, 3, 1, 0, 0, 0, 64'd951868800, 36};
        vecs[3] = '{2100, 3, 1, 0, 0, 0, 64'd4107542400, 136};
        vecs[4] = '{9999, 12, 31, 23, 59, 59, 64'd253402300799, 8044};
        vecs[5] = '{1970, 1, 2, 0, 0, 0, 64'd86400, 4};

        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.year_bcd = '0; bus.month_bcd = '0; bus.day_bcd = '0;
        bus.hour_bcd = '0; bus.minute_bcd = '0; bus.second_bcd = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_stamp", bus.time_stamp, 0);
        check("rst_err", bus.err, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].y, vecs[i].mo, vecs[i].d, vecs[i].h, vecs[i].mi, vecs[i].s);
            await_result(st, e, n, to);
            check($sformatf("vec%0d_timeout", i), to, 0);
            check($sformatf("vec%0d_stamp", i), st, vecs[i].stamp);
            check($sformatf("vec%0d_latency", i), n, vecs[i].n);
            check($sformatf("vec%0d_err", i), e, 0);
            take();
        end

        for (int i = 0; i < 25; i++) begin
            int y, mo, d, h, mi, s;
            y  = 1970 + int'($urandom_range(180));
            mo = 1 + int'($urandom_range(11));
            d  = 1 + int'($urandom_range(dim(y, mo) - 1));
            h  = int'($urandom_range(23));
            mi = int'($urandom_range(59));
            s  = int'($urandom_range(59));
            issue(y, mo, d, h, mi, s);
            await_result(st, e, n, to);
            check($sformatf("rnd%0d_stamp %0d-%0d-%0d", i, y, mo, d), st, ref_stamp(y, mo, d, h, mi, s));
            check($sformatf("rnd%0d_latency", i), n, (y - 1969) + mo + 2);
            check($sformatf("rnd%0d_err", i), e, 0);
            take();
        end

        // result held under back-pressure, then single-pulse release and immediate new accept
        issue(2024, 2, 29, 23, 59, 59);
        await_result(st, e, n, to);
        check("hold_first", st, ref_stamp(2024, 2, 29, 23, 59, 59));
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            check("hold_stamp", bus.time_stamp, ref_stamp(2024, 2, 29, 23, 59, 59));
            check("hold_in_ready", bus.in_ready, 0);
        end
        take();
        issue(1970, 1, 1, 0, 0, 0);
        await_result(st, e, n, to);
        check("after_hold_stamp", st, 0);
        check("after_hold_latency", n, 4);
        take();

        // reset in the middle of the year walk discards the conversion
        issue(2024, 9, 2, 12, 34, 56);
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_in_ready", bus.in_ready, 0);
        check("abort_stamp", bus.time_stamp, 0);
        rst_n = 1'b1;
        saw = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) saw++;
        end
        check("abort_no_result", saw, 0);
        issue(1970, 1, 2, 0, 0, 0);
        await_result(st, e, n, to);
        check("post_abort_stamp", st, 86400);
        take();

        // month 13
        issue(2024, 13, 1, 0, 0, 0);
        await_result(st, e, n, to);
`ifdef STAMP_RANGE_CHECK_EN
        check("range_err", e, 1);
        check("range_stamp", st, 0);
        check("range_latency", n, 2);
`else
        check("norange_err", e, 0);
        check("norange_terminates", to, 0);
`endif
        take();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
